// File: rtl/note_lane_scheduler.sv
// Falling-note pool for the guitar lanes: spawns, per-frame movement,
// strike scoring and exit detection, with registered outputs for the renderer.
module note_lane_scheduler #(
  parameter int LANES    = 4,
  parameter int SLOTS    = 4,
  parameter int Y_W      = 10,
  parameter int NOTE_H   = 50,
  parameter int SCREEN_H = 480,
  parameter int SPEED    = 1,
  parameter int HIT_TOP  = 350,
  parameter int HIT_BOT  = 370
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       song_done,
  input  logic                       frame_tick,
  input  logic                       note_valid,
  input  logic [LANES-1:0]           note_mask,
  output logic                       note_ready,
  input  logic [LANES-1:0]           press,
  output logic [LANES*SLOTS-1:0]     slot_valid,
  output logic [LANES*SLOTS*Y_W-1:0] slot_y,
  output logic [LANES-1:0]           hit,
  output logic [LANES-1:0]           miss,
  output logic                       overflow,
  output logic [15:0]                score,
  output logic [1:0]                 state_o
);

  localparam int N = LANES * SLOTS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [N-1:0]     vld, vld_n;
  logic [Y_W-1:0]   ypos [N];
  logic [Y_W-1:0]   ypos_n [N];
  logic [N-1:0]     struck;
  logic [LANES-1:0] hit_n, miss_n;
  logic             ovf_n;
  logic [15:0]      score_n;
  logic             active, spawn;

  assign active     = (state == RUN) || (state == DRAIN);
  assign note_ready = (state == RUN) & ~frame_tick;
  assign spawn      = note_valid & note_ready;

  always_comb begin
    logic           found;
    int             bi;
    logic [Y_W-1:0] by;
    logic [Y_W:0]   ny;
    logic [16:0]    sum;
    state_n = state;
    vld_n   = vld;
    for (int k = 0; k < N; k++) ypos_n[k] = ypos[k];
    struck  = '0;
    hit_n   = '0;
    miss_n  = '0;
    ovf_n   = 1'b0;
    score_n = score;
    found   = 1'b0;
    bi      = 0;
    by      = '0;
    ny      = '0;

    unique case (state)
      IDLE, DONE: if (start) begin
        state_n = RUN;
        score_n = '0;
      end
      RUN:   if (song_done) state_n = DRAIN;
      DRAIN: if (~|vld) state_n = DONE;
      default: ;
    endcase

    // strikes look at pre-move positions; deepest candidate wins
    for (int l = 0; l < LANES; l++) begin
      found = 1'b0;
      bi    = 0;
      by    = '0;
      if (active && press[l]) begin
        for (int s = 0; s < SLOTS; s++) begin
          if (vld[l*SLOTS+s] &&
              (32'(ypos[l*SLOTS+s]) + NOTE_H > HIT_TOP) &&
              (32'(ypos[l*SLOTS+s]) < HIT_BOT) &&
              (!found || ypos[l*SLOTS+s] > by)) begin
            found = 1'b1;
            bi    = s;
            by    = ypos[l*SLOTS+s];
          end
        end
        if (found) begin
          struck[l*SLOTS+bi] = 1'b1;
          vld_n[l*SLOTS+bi]  = 1'b0;
          ypos_n[l*SLOTS+bi] = '0;
          hit_n[l]           = 1'b1;
        end else begin
          miss_n[l] = 1'b1;
        end
      end
    end

    if (active && frame_tick) begin
      for (int k = 0; k < N; k++) begin
        if (vld[k] && !struck[k]) begin
          ny = {1'b0, ypos[k]} + (Y_W+1)'(SPEED);
          if (ny >= (Y_W+1)'(SCREEN_H)) begin
            vld_n[k]        = 1'b0;
            ypos_n[k]       = '0;
            miss_n[k/SLOTS] = 1'b1;
          end else begin
            ypos_n[k] = ny[Y_W-1:0];
          end
        end
      end
    end

    // free slots come from the registered state, so a struck slot waits a cycle
    if (spawn) begin
      for (int l = 0; l < LANES; l++) begin
        if (note_mask[l]) begin
          found = 1'b0;
          for (int s = 0; s < SLOTS; s++) begin
            if (!found && !vld[l*SLOTS+s]) begin
              found             = 1'b1;
              vld_n[l*SLOTS+s]  = 1'b1;
              ypos_n[l*SLOTS+s] = '0;
            end
          end
          if (!found) ovf_n = 1'b1;
        end
      end
    end

    sum = {1'b0, score_n};
    for (int l = 0; l < LANES; l++) sum = sum + 17'(hit_n[l]);
    score_n = sum[16] ? 16'hFFFF : sum[15:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      vld      <= '0;
      for (int k = 0; k < N; k++) ypos[k] <= '0;
      hit      <= '0;
      miss     <= '0;
      overflow <= 1'b0;
      score    <= '0;
    end else begin
      state    <= state_n;
      vld      <= vld_n;
      for (int k = 0; k < N; k++) ypos[k] <= ypos_n[k];
      hit      <= hit_n;
      miss     <= miss_n;
      overflow <= ovf_n;
      score    <= score_n;
    end
  end

  assign slot_valid = vld;
  assign state_o    = state;

  for (genvar k = 0; k < N; k++) begin : g_y
    assign slot_y[k*Y_W +: Y_W] = ypos[k];
  end

endmodule
